// File: rtl/lane_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : lane_renderer
//  Description : Multi-lane vertical stripe renderer for the VGA note highway.
//                Draws N_LANES coloured stripes from the pixel coordinate
//                stream. A lane flashes for FLASH_FRAMES frames after a
//                button press, and each lane shows a hit-zone band.
//                Output colour is registered (1-cycle latency).
//  Ports       : clk        - pixel/system clock
//                rst_n      - synchronous active-low reset
//                col, row   - current pixel coordinate (10 bits each)
//                valid      - high inside the visible region
//                lane_btn   - debounced, synchronised lane buttons (level)
//                lane_rgb   - registered 6-bit RGB pixel colour
//                lane_flash - per-lane flash indicator (registered state)
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_renderer #(
    parameter int                   N_LANES      = 5,
    parameter int                   LANE_X0      = 105,
    parameter int                   LANE_PITCH   = 70,
    parameter int                   STRIPE_W     = 35,
    parameter logic [6*N_LANES-1:0] LANE_COLORS  = 30'b110100_000011_111100_110000_001100,
    parameter logic [5:0]           FLASH_RGB    = 6'b111111,
    parameter logic [5:0]           HIT_RGB      = 6'b101010,
    parameter int                   HIT_Y0       = 400,
    parameter int                   HIT_Y1       = 420,
    parameter int                   FLASH_FRAMES = 6,
    parameter int                   V_VISIBLE    = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         col,
    input  logic [9:0]         row,
    input  logic               valid,
    input  logic [N_LANES-1:0] lane_btn,
    output logic [5:0]         lane_rgb,
    output logic [N_LANES-1:0] lane_flash
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if (N_LANES < 1 || N_LANES > 8) begin : g_bad_lanes
            $error("lane_renderer: N_LANES must be in 1..8");
        end
        if (LANE_X0 + (N_LANES - 1) * LANE_PITCH + STRIPE_W > 1023) begin : g_bad_geometry
            $error("lane_renderer: last lane extends beyond column 1023");
        end
        if (FLASH_FRAMES < 1 || FLASH_FRAMES > 255) begin : g_bad_flash
            $error("lane_renderer: FLASH_FRAMES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] c_flash_frames = 8'(FLASH_FRAMES);
    localparam logic [9:0] c_v_visible    = 10'(V_VISIBLE);
    localparam logic [9:0] c_hit_y0       = 10'(HIT_Y0);
    localparam logic [9:0] c_hit_y1       = 10'(HIT_Y1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLASH = 1'b1
    } lane_state_t;

    logic [N_LANES-1:0] r_btn_d;
    logic [N_LANES-1:0] w_press;
    logic [N_LANES-1:0] w_in_lane;
    logic [N_LANES-1:0] w_flashing;
    logic               r_frame_cond_d;
    logic               w_frame_cond;
    logic               w_tick;

    // ------------------------------------------------------------------
    // Button edge detect and frame tick. The history register resets to
    // all ones so a button held through reset must be released first.
    // The frame tick is edge-detected so a divided pixel clock that holds
    // (row,col) for several cycles still yields a single pulse per frame.
    // ------------------------------------------------------------------
    assign w_press      = lane_btn & ~r_btn_d;
    assign w_frame_cond = (row == c_v_visible) && (col == 10'd0);
    assign w_tick       = w_frame_cond & ~r_frame_cond_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_d        <= '1;
            r_frame_cond_d <= 1'b0;
        end else begin
            r_btn_d        <= lane_btn;
            r_frame_cond_d <= w_frame_cond;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane geometry and flash FSM
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N_LANES; g++) begin : g_lane
            localparam logic [10:0] c_lo = 11'(LANE_X0 + g * LANE_PITCH);
            localparam logic [10:0] c_hi = 11'(LANE_X0 + g * LANE_PITCH + STRIPE_W);

            lane_state_t r_state;
            lane_state_t w_state_nxt;
            logic [7:0]  r_cnt;
            logic [7:0]  w_cnt_nxt;

            // Strict bounds on both sides: the begin column itself is excluded.
            assign w_in_lane[g]  = ({1'b0, col} > c_lo) && ({1'b0, col} < c_hi);
            assign w_flashing[g] = (r_state == S_FLASH);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // A press (new or retrigger) outranks a same-cycle frame tick.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    S_IDLE: begin
                        if (w_press[g]) begin
                            w_state_nxt = S_FLASH;
                            w_cnt_nxt   = c_flash_frames;
                        end
                    end
                    S_FLASH: begin
                        if (w_press[g]) begin
                            w_cnt_nxt = c_flash_frames;
                        end else if (w_tick) begin
                            if (r_cnt == 8'd1) begin
                                w_state_nxt = S_IDLE;
                                w_cnt_nxt   = 8'd0;
                            end else begin
                                w_cnt_nxt = r_cnt - 8'd1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end
                endcase
            end
        end
    endgenerate

    assign lane_flash = w_flashing;

    // ------------------------------------------------------------------
    // Colour selection: lowest-index lane wins; uses registered flash state.
    // ------------------------------------------------------------------
    logic       w_win_any;
    logic       w_win_flash;
    logic [5:0] w_win_rgb;
    logic       w_hit_row;
    logic [5:0] w_rgb_nxt;

    always_comb begin
        w_win_any   = 1'b0;
        w_win_flash = 1'b0;
        w_win_rgb   = 6'd0;
        // Walk from the top index down so the lowest matching lane is last to write.
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (w_in_lane[i]) begin
                w_win_any   = 1'b1;
                w_win_flash = w_flashing[i];
                w_win_rgb   = LANE_COLORS[6*i +: 6];
            end
        end
    end

    assign w_hit_row = (row >= c_hit_y0) && (row <= c_hit_y1);

    always_comb begin
        w_rgb_nxt = 6'd0;
        if (valid && w_win_any) begin
            if (w_win_flash) begin
                w_rgb_nxt = FLASH_RGB;
            end else if (w_hit_row) begin
                w_rgb_nxt = HIT_RGB;
            end else begin
                w_rgb_nxt = w_win_rgb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_rgb <= 6'd0;
        end else begin
            lane_rgb <= w_rgb_nxt;
        end
    end

endmodule
`default_nettype wire
